// File: rtl/spart_pkg.sv
// spart_pkg: shared types, SPART register addresses and baud divisor helper for the buffered driver.
package spart_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_CFG_LO, ST_CFG_HI, ST_RUN} drv_state_t;
  localparam logic [1:0] IOADDR_DATA   = 2'b00;
  localparam logic [1:0] IOADDR_STATUS = 2'b01;
  localparam logic [1:0] IOADDR_DBL    = 2'b10;
  localparam logic [1:0] IOADDR_DBH    = 2'b11;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  function automatic logic [15:0] baud_div(input int unsigned clk_hz, input logic [1:0] sel);
    int unsigned baud;
    baud = 32'd4800 << sel;
    return 16'(clk_hz / (16 * baud) - 1);
  endfunction
endpackage

// File: rtl/spart_buffered_driver_if.sv
// spart_buffered_driver_if: SPART host bus; both tristate drivers of databus live here.
interface spart_buffered_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;
  logic       drv_oe;
  logic [7:0] drv_data;
  logic       spart_oe;
  logic [7:0] spart_data;
  wire  [7:0] databus;
  assign databus = drv_oe ? drv_data : 8'hzz;
  assign databus = spart_oe ? spart_data : 8'hzz;
  modport master(output iocs, iorw, ioaddr, drv_oe, drv_data, input rda, tbr, databus);
  modport slave(input iocs, iorw, ioaddr, databus, output rda, tbr, spart_oe, spart_data);
endinterface

// File: rtl/spart_drv_fifo.sv
// spart_drv_fifo: byte FIFO with wrapping pointers; push and pop are never requested together.
module spart_drv_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  always_comb begin
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = push ? cnt_q + 1'b1 : pop ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= din;
  assign dout  = mem[rd_q];
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/spart_buffered_driver.sv
// spart_buffered_driver: programs the SPART baud divisor, then echoes received bytes through a FIFO.
// Defining SPART_DRV_LINE_MODE_EN holds bytes until CR or a full FIFO starts a flush.
module spart_buffered_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              br_cfg,
  spart_buffered_driver_if.master bus,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    cfg_done
);
  localparam int CW = $clog2(DEPTH) + 1;
  drv_state_t  state_q, state_d;
  logic [1:0]  br_q, br_d;
  logic [15:0] div;
  logic        push, pop, full, empty, wr_ok;
  logic [7:0]  head;
  // br_q is captured on the low-byte write so both divisor halves use one setting
  assign div = baud_div(CLK_HZ, state_q == ST_CFG_HI ? br_q : br_cfg);
  spart_drv_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(bus.databus),
    .dout(head), .full(full), .empty(empty), .count(fifo_count)
  );
`ifdef SPART_DRV_LINE_MODE_EN
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  logic flushing_q, flushing_d;
  always_comb
    flushing_d = (push && (bus.databus == ASCII_CR || fifo_count == CNT_LAST)) ? 1'b1 :
                 (pop && fifo_count == CNT_ONE) ? 1'b0 : flushing_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flushing_q <= 1'b0;
    else flushing_q <= flushing_d;
  assign wr_ok = flushing_q;
`else
  assign wr_ok = 1'b1;
`endif
  always_comb begin
    state_d      = state_q;
    br_d         = br_q;
    push         = 1'b0;
    pop          = 1'b0;
    bus.iocs     = 1'b0;
    bus.iorw     = 1'b0;
    bus.ioaddr   = IOADDR_DATA;
    bus.drv_oe   = 1'b0;
    bus.drv_data = 8'h00;
    cfg_done     = state_q == ST_RUN;
    case (state_q)
      ST_INIT: state_d = ST_CFG_LO;
      ST_CFG_LO: begin
        state_d      = ST_CFG_HI;
        br_d         = br_cfg;
        bus.iocs     = 1'b1;
        bus.ioaddr   = IOADDR_DBL;
        bus.drv_oe   = 1'b1;
        bus.drv_data = div[7:0];
      end
      ST_CFG_HI: begin
        state_d      = ST_RUN;
        bus.iocs     = 1'b1;
        bus.ioaddr   = IOADDR_DBH;
        bus.drv_oe   = 1'b1;
        bus.drv_data = div[15:8];
      end
      default:
        if (br_cfg != br_q) state_d = ST_CFG_LO;
        else if (bus.rda && !full) begin
          bus.iocs = 1'b1;
          bus.iorw = 1'b1;
          push     = 1'b1;
        end else if (bus.tbr && !empty && wr_ok) begin
          bus.iocs     = 1'b1;
          bus.drv_oe   = 1'b1;
          bus.drv_data = head;
          pop          = 1'b1;
        end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_INIT;
      br_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
    end
endmodule

// File: tb/tb_spart_buffered_driver.sv
// tb_spart_buffered_driver: vector table, corner sequences and a queue-model random run with a SPART bus model.
module tb_spart_buffered_driver;
  localparam int DEPTH = 16;
`ifdef SPART_DRV_LINE_MODE_EN
  localparam bit LINE = 1'b1;
`else
  localparam bit LINE = 1'b0;
`endif
  typedef struct {
    logic [1:0] br;
    bit         rda;
    bit         tbr;
    logic [7:0] rxb;
    int         tx;
    int         cnt;
    int         done;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic [4:0] fifo_count;
  logic       cfg_done;
  spart_buffered_driver_if bus();
  spart_buffered_driver #(.CLK_HZ(50_000_000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .br_cfg(br_cfg), .bus(bus.master),
    .fifo_count(fifo_count), .cfg_done(cfg_done)
  );
  always #5 clk = ~clk;
  assign bus.spart_oe = bus.iocs && bus.iorw;

  int checks = 0, failures = 0;
  int o_tx, o_cnt, o_done;
  logic [7:0] rx_q[$];
  int tx_q[$];
  bit tbr_en;
  logic [1:0] br_val;
  vec_t tv[6];

  // Transfer encoding: {iocs, iorw, ioaddr, data}; data is zero when idle.
  function automatic int wr(int a, int d); return (1 << 11) | (a << 8) | d; endfunction
  function automatic int rd(int d); return (3 << 10) | d; endfunction
  function automatic int div_of(int sel); return 50_000_000 / (16 * (4800 << sel)) - 1; endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic [1:0] br, bit rda, bit tbr, logic [7:0] rxb);
    @(negedge clk);
    br_cfg = br;
    bus.rda = rda;
    bus.tbr = tbr;
    bus.spart_data = rxb;
    #1;
    o_tx = bus.iocs ? {20'd0, bus.iocs, bus.iorw, bus.ioaddr, bus.databus}
                    : {20'd0, bus.iocs, bus.iorw, bus.ioaddr, 8'h00};
    o_cnt = int'(fifo_count);
    o_done = int'(cfg_done);
  endtask

  task automatic spart(int n);
    repeat (n) begin
      drive(br_val, rx_q.size() > 0, tbr_en, rx_q.size() > 0 ? rx_q[0] : 8'h00);
      if (o_tx[11] && o_tx[10]) void'(rx_q.pop_front());
      else if (o_tx[11]) tx_q.push_back(o_tx);
    end
  endtask

  task automatic reset_cfg(logic [1:0] br);
    @(negedge clk);
    rst_n = 1'b0;
    rx_q.delete();
    tx_q.delete();
    tbr_en = 1'b0;
    br_val = br;
    br_cfg = br;
    bus.rda = 1'b0;
    bus.tbr = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(br, 0, 0, 8'h00);
    chk("cfg_init", o_tx, 0);
    drive(br, 0, 0, 8'h00);
    chk("cfg_lo", o_tx, wr(2, div_of(br) & 255));
    chk("cfg_lo_done", o_done, 0);
    drive(br, 0, 0, 8'h00);
    chk("cfg_hi", o_tx, wr(3, div_of(br) >> 8));
  endtask

  initial begin
    logic [7:0] exp_b[$];
    logic [7:0] mq[$];
    logic [7:0] b;
    int ph, exp_tx, exp_cnt, exp_done;
    logic [1:0] m_br, m_lat;
    bit m_fl, rda_i, tbr_i;
    bus.rda = 1'b0;
    bus.tbr = 1'b0;
    bus.spart_data = 8'h00;
    tbr_en = 1'b0;
    br_val = 2'b01;

    // reset holds everything idle even with rda/tbr active
    repeat (2) begin
      drive(2'b01, 1, 1, 8'h55);
      chk("rst_tx", o_tx, 0);
      chk("rst_cnt", o_cnt, 0);
      chk("rst_done", o_done, 0);
    end

    tv[0] = '{2'd1, 1'b0, 1'b0, 8'h00, 0, 0, 0, "t_init"};
    tv[1] = '{2'd1, 1'b0, 1'b0, 8'h00, wr(2, 'h44), 0, 0, "t_cfg_lo"};
    tv[2] = '{2'd1, 1'b0, 1'b0, 8'h00, wr(3, 'h01), 0, 0, "t_cfg_hi"};
    tv[3] = '{2'd1, 1'b1, 1'b1, 8'h41, rd('h41), 0, 1, "t_read"};
    tv[4] = '{2'd1, 1'b0, 1'b1, 8'h00, LINE ? 0 : wr(0, 'h41), 1, 1, "t_echo"};
    tv[5] = '{2'd1, 1'b0, 1'b1, 8'h00, 0, LINE ? 1 : 0, 1, "t_idle"};
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(tv[i].br, tv[i].rda, tv[i].tbr, tv[i].rxb);
      chk({tv[i].name, "_tx"}, o_tx, tv[i].tx);
      chk({tv[i].name, "_cnt"}, o_cnt, tv[i].cnt);
      chk({tv[i].name, "_done"}, o_done, tv[i].done);
    end

    // full FIFO ignores rda, then drains in order
    reset_cfg(2'b01);
    for (int i = 0; i < 17; i++) rx_q.push_back(8'(i));
    spart(24);
    chk("full_count", o_cnt, 16);
    chk("full_pending", rx_q.size(), 1);
    tbr_en = 1'b1;
    spart(40);
    chk("drain_n", tx_q.size(), 17);
    for (int i = 0; i < 17; i++) chk("drain_byte", i < tx_q.size() ? tx_q[i] : -1, wr(0, i));
    chk("drain_empty", o_cnt, 0);

    // run-time reconfiguration with bytes buffered
    reset_cfg(2'b00);
    exp_b.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(8'h20, 8'h7E));
      rx_q.push_back(b);
      exp_b.push_back(b);
    end
    spart(6);
    chk("rc_count", o_cnt, 3);
    drive(2'b11, 0, 0, 8'h00);
    chk("rc_decide", o_tx, 0);
    chk("rc_decide_done", o_done, 1);
    drive(2'b11, 0, 0, 8'h00);
    chk("rc_lo", o_tx, wr(2, 'h50));
    chk("rc_lo_done", o_done, 0);
    drive(2'b11, 0, 0, 8'h00);
    chk("rc_hi", o_tx, wr(3, 'h00));
    chk("rc_hi_done", o_done, 0);
    chk("rc_hi_count", o_cnt, 3);
    br_val = 2'b11;
    tbr_en = 1'b1;
    if (LINE) begin
      rx_q.push_back(8'h0D);
      exp_b.push_back(8'h0D);
    end
    spart(12);
    chk("rc_echo_n", tx_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size(); i++)
      chk("rc_echo", i < tx_q.size() ? tx_q[i] : -1, wr(0, int'(exp_b[i])));

    // asynchronous reset mid-operation
    reset_cfg(2'b10);
    for (int i = 0; i < 5; i++) rx_q.push_back(8'(8'h30 + i));
    spart(8);
    chk("ar_count_pre", o_cnt, 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", int'(fifo_count), 0);
    chk("ar_iocs", int'(bus.iocs), 0);
    chk("ar_done", int'(cfg_done), 0);
    reset_cfg(2'b10);

`ifdef SPART_DRV_LINE_MODE_EN
    reset_cfg(2'b01);
    tbr_en = 1'b1;
    rx_q.push_back("a");
    rx_q.push_back("b");
    rx_q.push_back("c");
    spart(8);
    chk("ln_hold_tx", tx_q.size(), 0);
    chk("ln_hold_cnt", o_cnt, 3);
    rx_q.push_back(8'h0D);
    spart(10);
    chk("ln_flush_n", tx_q.size(), 4);
    chk("ln_a", tx_q.size() > 0 ? tx_q[0] : -1, wr(0, "a"));
    chk("ln_b", tx_q.size() > 1 ? tx_q[1] : -1, wr(0, "b"));
    chk("ln_c", tx_q.size() > 2 ? tx_q[2] : -1, wr(0, "c"));
    chk("ln_cr", tx_q.size() > 3 ? tx_q[3] : -1, wr(0, 'h0D));
    rx_q.push_back("x");
    spart(5);
    chk("ln_cleared_tx", tx_q.size(), 4);
    chk("ln_cleared_cnt", o_cnt, 1);
`endif

    // randomized run against a queue model of the rules
    reset_cfg(2'($urandom_range(0, 3)));
    ph = 0;
    m_br = br_val;
    m_lat = br_val;
    m_fl = 1'b0;
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 45)
        rx_q.push_back((LINE && $urandom_range(0, 9) == 0) ? 8'h0D : 8'($urandom));
      tbr_en = $urandom_range(0, 99) < (((c / 100) % 2) ? 80 : 20);
      if ($urandom_range(0, 149) == 0) br_val = 2'($urandom_range(0, 3));
      rda_i = rx_q.size() > 0;
      tbr_i = tbr_en;
      b = rda_i ? rx_q[0] : 8'h00;
      exp_cnt = mq.size();
      exp_done = ph == 0;
      exp_tx = 0;
      if (ph == 1) begin
        exp_tx = wr(2, div_of(br_val) & 255);
        m_lat = br_val;
        ph = 2;
      end else if (ph == 2) begin
        exp_tx = wr(3, div_of(m_lat) >> 8);
        m_br = m_lat;
        ph = 0;
      end else if (br_val != m_br) ph = 1;
      else if (rda_i && mq.size() < DEPTH) begin
        exp_tx = rd(int'(b));
        mq.push_back(b);
        if (b == 8'h0D || mq.size() == DEPTH) m_fl = 1'b1;
      end else if (tbr_i && mq.size() > 0 && (!LINE || m_fl)) begin
        exp_tx = wr(0, int'(mq.pop_front()));
        if (mq.size() == 0) m_fl = 1'b0;
      end
      drive(br_val, rda_i, tbr_i, b);
      if (o_tx[11] && o_tx[10] && rx_q.size() > 0) void'(rx_q.pop_front());
      chk("rnd_tx", o_tx, exp_tx);
      chk("rnd_cnt", o_cnt, exp_cnt);
      chk("rnd_done", o_done, exp_done);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
